// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, load formatting and writeback mux.
// Also counts retired instructions and flags misaligned loads.
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_RegWrite,
    input  logic [1:0]       in_wb_sel,
    input  logic [4:0]       in_rd,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_mem_data,
    input  logic [31:0]      in_pc4,
    output logic             RegWrite,
    output logic [4:0]       wr,
    output logic [31:0]      wd,
    output logic             load_misalign,
    output logic [CNT_W-1:0] instret
);

    logic        valid_q;
    logic        regwrite_q;
    logic [1:0]  sel_q;
    logic [4:0]  rd_q;
    logic [2:0]  funct3_q;
    logic [31:0] alu_q;
    logic [31:0] mem_q;
    logic [31:0] pc4_q;

    logic [1:0]  off;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ld_data;
    logic        is_load;
    logic        is_half;
    logic        is_word;
    logic        retire;

    // MEM/WB register: flush wins over stall, stall holds everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            sel_q      <= 2'b00;
            rd_q       <= 5'd0;
            funct3_q   <= 3'b000;
            alu_q      <= 32'd0;
            mem_q      <= 32'd0;
            pc4_q      <= 32'd0;
        end else if (flush) begin
            valid_q    <= 1'b0;
        end else if (!stall) begin
            valid_q    <= in_valid;
            regwrite_q <= in_RegWrite;
            sel_q      <= in_wb_sel;
            rd_q       <= in_rd;
            funct3_q   <= in_funct3;
            alu_q      <= in_alu_result;
            mem_q      <= in_mem_data;
            pc4_q      <= in_pc4;
        end
    end

    // Extract and extend the addressed byte/halfword of the load word
    always_comb begin
        off    = alu_q[1:0];
        byte_v = mem_q[{off, 3'b000} +: 8];
        half_v = off[1] ? mem_q[31:16] : mem_q[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{byte_v[7]}}, byte_v};
            3'b100:  ld_data = {24'd0, byte_v};
            3'b001:  ld_data = {{16{half_v[15]}}, half_v};
            3'b101:  ld_data = {16'd0, half_v};
            default: ld_data = mem_q;
        endcase
    end

    // Misaligned halfword/word load detection
    always_comb begin
        is_load       = valid_q && (sel_q == 2'b01);
        is_half       = (funct3_q[1:0] == 2'b01);
        is_word       = (funct3_q == 3'b010);
        load_misalign = is_load &&
                        ((is_half && off[0]) ||
                         (is_word && (off != 2'b00)));
    end

    // Writeback source select and register file write enable
    always_comb begin
        wr = rd_q;
        unique case (1'b1)
            sel_q == 2'b00: wd = alu_q;
            sel_q == 2'b01: wd = ld_data;
            sel_q == 2'b10: wd = pc4_q;
            default:        wd = 32'd0;
        endcase
        RegWrite = valid_q && regwrite_q &&
                   (rd_q != 5'd0) && !load_misalign;
    end

    assign retire = valid_q && !stall && !flush && !load_misalign;

    // Retired-instruction counter, counts on the edge an instruction leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + CNT_W'(1);
        end
    end

endmodule
